// File: rtl/fb_scanout.sv
// fb_scanout: 640x480 VGA-style raster scanout of an 8-bit grayscale framebuffer, centred image.
// Optional build macro SCANOUT_BORDER_EN draws a 1-pixel white ring around the image rectangle.
module fb_scanout #(
    parameter int         H_ACTIVE = 640,
    parameter int         H_FP     = 16,
    parameter int         H_SYNC   = 96,
    parameter int         H_BP     = 48,
    parameter int         V_ACTIVE = 480,
    parameter int         V_FP     = 10,
    parameter int         V_SYNC   = 2,
    parameter int         V_BP     = 33,
    parameter int         FB_DEPTH = 76800,
    parameter logic [7:0] BG_COLOR = 8'h00
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [10:0] IMG_WIDTH_OUT,
    input  logic [9:0]  IMG_HEIGHT_OUT,
    input  logic        enable,
    input  logic [7:0]  PIXEL_IN,
    output logic [16:0] R_ADDR,
    output logic        rden_out,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT_W = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_ACT_W = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [18:0] DEPTH_W = 19'(FB_DEPTH);

    // Stage 0: raster counters and per-frame latched geometry
    logic [10:0] h_q;
    logic [9:0]  v_q;
    logic [9:0]  w_q;
    logic [9:0]  ht_q;
    logic        en_q;
    logic [18:0] row_base_q;

    logic        at_origin, line_end, frame_end;
    logic [9:0]  w_clamp, ht_clamp, w_cur, ht_cur;
    logic        en_cur;
    logic [10:0] x_diff, h_end, v_end, rel_x;
    logic [9:0]  y_diff, x_off, y_off;
    logic        h_in, v_in, active, hs, vs, in_img;
    logic [18:0] addr;

    assign at_origin = (h_q == 11'd0) && (v_q == 10'd0);
    assign line_end  = (h_q == H_LAST);
    assign frame_end = line_end && (v_q == V_LAST);

    assign w_clamp  = (IMG_WIDTH_OUT > H_ACT_W) ? H_ACT_W[9:0] : IMG_WIDTH_OUT[9:0];
    assign ht_clamp = (IMG_HEIGHT_OUT > V_ACT_W) ? V_ACT_W : IMG_HEIGHT_OUT;

    // At (0,0) the fresh inputs are used directly so the very first pixel already sees the new geometry
    assign w_cur  = at_origin ? w_clamp  : w_q;
    assign ht_cur = at_origin ? ht_clamp : ht_q;
    assign en_cur = at_origin ? enable   : en_q;

    assign x_diff = H_ACT_W - {1'b0, w_cur};
    assign x_off  = x_diff[10:1];
    assign y_diff = V_ACT_W - ht_cur;
    assign y_off  = {1'b0, y_diff[9:1]};
    assign h_end  = {1'b0, x_off} + {1'b0, w_cur};
    assign v_end  = {1'b0, y_off} + {1'b0, ht_cur};

    assign h_in   = (h_q >= {1'b0, x_off}) && (h_q < h_end);
    assign v_in   = ({1'b0, v_q} >= {1'b0, y_off}) && ({1'b0, v_q} < v_end);
    assign active = (h_q < H_ACT_W) && (v_q < V_ACT_W);
    assign hs     = !((h_q >= HS_BEG) && (h_q < HS_END));
    assign vs     = !((v_q >= VS_BEG) && (v_q < VS_END));

    assign rel_x  = h_q - {1'b0, x_off};
    assign addr   = row_base_q + {8'd0, rel_x};
    assign in_img = active && h_in && v_in && en_cur && (addr < DEPTH_W);

`ifdef SCANOUT_BORDER_EN
    logic bx, by, border;
    logic border_q1, border_q2;
    // h+1 / v+1 keep the left and top ring sides off-screen when the offset is zero
    assign bx     = (h_q + 11'd1 >= {1'b0, x_off}) && (h_q <= h_end);
    assign by     = ({1'b0, v_q} + 11'd1 >= {1'b0, y_off}) && ({1'b0, v_q} <= v_end);
    assign border = active && en_cur && (w_cur != 10'd0) && (ht_cur != 10'd0)
                    && bx && by && !(h_in && v_in);
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            h_q        <= '0;
            v_q        <= '0;
            w_q        <= '0;
            ht_q       <= '0;
            en_q       <= 1'b0;
            row_base_q <= '0;
        end else begin
            if (at_origin) begin
                w_q  <= w_clamp;
                ht_q <= ht_clamp;
                en_q <= enable;
            end
            if (line_end) begin
                h_q <= '0;
                v_q <= frame_end ? 10'd0 : v_q + 10'd1;
            end else begin
                h_q <= h_q + 11'd1;
            end
            if (frame_end) begin
                row_base_q <= '0;
            end else if (line_end && v_in) begin
                row_base_q <= row_base_q + {9'd0, w_cur};
            end
        end
    end

    // Stage 1: read request plus delayed raster flags
    logic [16:0] raddr_q;
    logic        rden_q;
    logic        in_img_q1, active_q1, hs_q1, vs_q1, fs_q1;
    // Stage 2: aligned with RAM read data
    logic        in_img_q2, active_q2, hs_q2, vs_q2, fs_q2;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            raddr_q   <= '0;
            rden_q    <= 1'b0;
            in_img_q1 <= 1'b0;
            active_q1 <= 1'b0;
            hs_q1     <= 1'b1;
            vs_q1     <= 1'b1;
            fs_q1     <= 1'b0;
            in_img_q2 <= 1'b0;
            active_q2 <= 1'b0;
            hs_q2     <= 1'b1;
            vs_q2     <= 1'b1;
            fs_q2     <= 1'b0;
        end else begin
            rden_q    <= in_img;
            if (in_img) begin
                raddr_q <= addr[16:0];
            end
            in_img_q1 <= in_img;
            active_q1 <= active;
            hs_q1     <= hs;
            vs_q1     <= vs;
            fs_q1     <= at_origin;
            in_img_q2 <= in_img_q1;
            active_q2 <= active_q1;
            hs_q2     <= hs_q1;
            vs_q2     <= vs_q1;
            fs_q2     <= fs_q1;
        end
    end

`ifdef SCANOUT_BORDER_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            border_q1 <= 1'b0;
            border_q2 <= 1'b0;
        end else begin
            border_q1 <= border;
            border_q2 <= border_q1;
        end
    end
`endif

    // RAM data arrives with the stage-2 flags, so the pixel mux is combinational on PIXEL_IN
    logic [7:0] pix;
    always_comb begin
        pix = 8'h00;
        if (in_img_q2) begin
            pix = PIXEL_IN;
`ifdef SCANOUT_BORDER_EN
        end else if (border_q2) begin
            pix = 8'hFF;
`endif
        end else if (active_q2) begin
            pix = BG_COLOR;
        end
    end

    assign R_ADDR      = raddr_q;
    assign rden_out    = rden_q;
    assign VGA_R       = pix;
    assign VGA_G       = pix;
    assign VGA_B       = pix;
    assign VGA_HS      = hs_q2;
    assign VGA_VS      = vs_q2;
    assign VGA_BLANK_N = active_q2;
    assign frame_start = fs_q2;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout on a reduced raster (80x55 total, 64x48 active) so several frames fit in a short run.
module tb_fb_scanout;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 48, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int DEPTH = 768;
`ifdef SCANOUT_BORDER_EN
    localparam int BRD = 255;
`else
    localparam int BRD = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] img_w = 11'd16;
    logic [9:0]  img_h = 10'd12;
    logic        en = 1'b1;
    logic [7:0]  ram_q = 8'h00;
    logic [16:0] R_ADDR;
    logic        rden_out;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N, frame_start;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    logic mon_en = 1'b0;
    int hs_lo[6] = '{default: 0};
    int vs_lo[6] = '{default: 0};
    int blank_hi[6] = '{default: 0};
    int fs_cnt[6] = '{default: 0};
    int rd_cnt[6] = '{default: 0};
    int exp_rd[6];

    fb_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FB_DEPTH(DEPTH), .BG_COLOR(8'h00)
    ) dut (
        .CLK(clk), .RESET(rst_n),
        .IMG_WIDTH_OUT(img_w), .IMG_HEIGHT_OUT(img_h), .enable(en),
        .PIXEL_IN(ram_q), .R_ADDR(R_ADDR), .rden_out(rden_out),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Frame RAM model: data = address low byte, one cycle after the read strobe
    always @(posedge clk) if (rden_out) ram_q <= R_ADDR[7:0];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Output at edge k belongs to raster position k-2; the read strobe to position k-1
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (cyc >= 2 && (cyc - 2) / FT < 6) begin
                hs_lo[(cyc - 2) / FT]    += (VGA_HS == 1'b0) ? 1 : 0;
                vs_lo[(cyc - 2) / FT]    += (VGA_VS == 1'b0) ? 1 : 0;
                blank_hi[(cyc - 2) / FT] += (VGA_BLANK_N == 1'b1) ? 1 : 0;
                fs_cnt[(cyc - 2) / FT]   += (frame_start == 1'b1) ? 1 : 0;
            end
            if (cyc >= 1 && (cyc - 1) / FT < 6 && rden_out)
                rd_cnt[(cyc - 1) / FT] += 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("check %s: %0d ok", tag, got);
        end
    endtask

    task automatic run_to(input int k);
        int guard = 0;
        while (cyc < k && guard < 50000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < k) check_val("run_to_timeout", cyc, k);
    endtask

    task automatic check_px(input string tag, input int p, input logic exp_rd_i,
                            input int exp_addr, input int exp_pix);
        logic [7:0] e8;
        e8 = 8'(exp_pix);
        run_to(p + 1);
        check_val({tag, ".rden"}, {31'd0, rden_out}, {31'd0, exp_rd_i});
        check_val({tag, ".addr"}, {15'd0, R_ADDR}, exp_addr);
        run_to(p + 2);
        check_val({tag, ".rgb"}, {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, e8, e8, e8});
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, ".addr"}, {15'd0, R_ADDR}, 0);
        check_val({tag, ".rden"}, {31'd0, rden_out}, 0);
        check_val({tag, ".rgb"}, {8'd0, VGA_R, VGA_G, VGA_B}, 0);
        check_val({tag, ".hs_vs"}, {30'd0, VGA_HS, VGA_VS}, 3);
        check_val({tag, ".blank_fs"}, {30'd0, VGA_BLANK_N, frame_start}, 0);
    endtask

    initial begin
        exp_rd = '{192, 192, 384, 0, 768, 429};
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs("rst0");
        rst_n = 1'b1;
        mon_en = 1'b1;

        run_to(1); check_val("fs_e1", {31'd0, frame_start}, 0);
        run_to(2); check_val("fs_e2", {31'd0, frame_start}, 1);
        run_to(3); check_val("fs_e3", {31'd0, frame_start}, 0);
        run_to(67 + 2); check_val("hs_h67", {31'd0, VGA_HS}, 1);
        run_to(68 + 2); check_val("hs_h68", {31'd0, VGA_HS}, 0);

        // Frame 0: 16x12 centred at (24,18)
        check_px("f0_left", 18 * HT + 23, 1'b0, 0, BRD);
        check_px("f0_first", 18 * HT + 24, 1'b1, 0, 0);
        check_px("f0_second", 18 * HT + 25, 1'b1, 1, 1);
        check_px("f0_eol", 18 * HT + 39, 1'b1, 15, 15);
        check_px("f0_right", 18 * HT + 40, 1'b0, 15, BRD);
        check_px("f0_row1", 19 * HT + 24, 1'b1, 16, 16);
        check_px("f0_last", 29 * HT + 39, 1'b1, 191, 191);

        // Width change mid-frame 1 only lands in frame 2
        run_to(FT + 200); img_w = 11'd32;
        check_px("f1_left", FT + 18 * HT + 23, 1'b0, 191, BRD);
        check_px("f1_first", FT + 18 * HT + 24, 1'b1, 0, 0);
        check_px("f1_second", FT + 18 * HT + 25, 1'b1, 1, 1);
        check_px("f1_oldw", FT + 18 * HT + 40, 1'b0, 15, BRD);

        check_px("f2_left", 2 * FT + 18 * HT + 15, 1'b0, 191, BRD);
        check_px("f2_first", 2 * FT + 18 * HT + 16, 1'b1, 0, 0);
        check_px("f2_eol", 2 * FT + 18 * HT + 47, 1'b1, 31, 31);
        check_px("f2_row1", 2 * FT + 19 * HT + 16, 1'b1, 32, 32);
        run_to(2 * FT + 2000); en = 1'b0;

        check_px("f3_off", 3 * FT + 18 * HT + 25, 1'b0, 383, 0);
        run_to(3 * FT + 2000); en = 1'b1; img_w = 11'd64; img_h = 10'd48;

        // Full screen: only the first DEPTH words are read
        check_px("f4_origin", 4 * FT, 1'b1, 0, 0);
        check_px("f4_x1", 4 * FT + 1, 1'b1, 1, 1);
        check_px("f4_end", 4 * FT + 11 * HT + 63, 1'b1, 767, 255);
        check_px("f4_bg", 4 * FT + 12 * HT, 1'b0, 767, 0);
        run_to(4 * FT + 2000); img_w = 11'd33; img_h = 10'd13;

        // Odd margins round down: x_off=15, y_off=17
        check_px("f5_left", 5 * FT + 17 * HT + 14, 1'b0, 767, BRD);
        check_px("f5_first", 5 * FT + 17 * HT + 15, 1'b1, 0, 0);
        check_px("f5_eol", 5 * FT + 17 * HT + 47, 1'b1, 32, 32);
        check_px("f5_row1", 5 * FT + 18 * HT + 15, 1'b1, 33, 33);

        run_to(6 * FT + 2);
        for (int f = 0; f < 6; f++) begin
            check_val($sformatf("f%0d.fs_count", f), fs_cnt[f], 1);
            check_val($sformatf("f%0d.hs_low", f), hs_lo[f], HS * VT);
            check_val($sformatf("f%0d.vs_low", f), vs_lo[f], VS * HT);
            check_val($sformatf("f%0d.blank_hi", f), blank_hi[f], HA * VA);
            check_val($sformatf("f%0d.reads", f), rd_cnt[f], exp_rd[f]);
        end

        // Asynchronous reset in the middle of the image area
        run_to(6 * FT + 20 * HT + 30 + 1);
        check_val("pre_rst.rden", {31'd0, rden_out}, 1);
        check_val("pre_rst.addr", {15'd0, R_ADDR}, 3 * 33 + 15);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        run_to(1); check_val("rfs_e1", {31'd0, frame_start}, 0);
        run_to(2); check_val("rfs_e2", {31'd0, frame_start}, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
